// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch (I) and data (D) ports.
// One access at a time: IDLE grants, BUSY drives the memory, and RESP pulses the owner's ack.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_cs,
    input  logic          dm_r,
    input  logic          dm_w,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic [1:0]    d_streak_reg;
    logic [1:0]    d_streak_next;
    logic          owner_reg;      // 1 = data port owns the access
    logic          mem_en_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;

    logic dm_valid;
    logic grant_d;
    logic grant_i;
    logic finish;

    assign dm_valid = dm_cs & (dm_r | dm_w);
    // Data wins ties unless it has already taken two grants in a row past a waiting fetch.
    assign grant_d  = (state_reg == ST_IDLE) && dm_valid && !((d_streak_reg == 2'd2) && if_req);
    assign grant_i  = (state_reg == ST_IDLE) && !grant_d && if_req;
    assign finish   = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);

    always_comb begin
        d_streak_next = d_streak_reg;
        if (grant_i) begin
            d_streak_next = 2'd0;
        end else if (grant_d) begin
            if (!if_req) begin
                d_streak_next = 2'd0;
            end else if (d_streak_reg != 2'd2) begin
                d_streak_next = d_streak_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            d_streak_reg  <= 2'd0;
            owner_reg     <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            d_streak_reg <= d_streak_next;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_d || grant_i) begin
                        state_reg     <= ST_BUSY;
                        owner_reg     <= grant_d;
                        cnt_reg       <= CNT_LOAD;
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= grant_d & dm_w;
                        mem_addr_reg  <= grant_d ? dm_addr : if_addr;
                        mem_wdata_reg <= grant_d ? dm_wdata : '0;
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg  <= ST_RESP;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-port response channel: index 0 is fetch, index 1 is data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            localparam logic OWN = (gi == 1);
            logic          ack_reg;
            logic [DW-1:0] rdata_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= finish && (owner_reg == OWN);
                    if (finish && (owner_reg == OWN) && !mem_we_reg) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign if_ack    = g_chan[0].ack_reg;
    assign if_rdata  = g_chan[0].rdata_reg;
    assign dm_ack    = g_chan[1].ack_reg;
    assign dm_rdata  = g_chan[1].rdata_reg;

    assign stall_f   = if_req & ~if_ack;
    assign stall_m   = dm_valid & ~dm_ack;

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing scenarios followed by random
// traffic on both ports, checked against a sparse-memory reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int W = 3;
    localparam int P = W + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_cs = 1'b0, dm_r = 1'b0, dm_w = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack, stall_f, stall_m, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(W), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } dm_op_t;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    dm_op_t      dq[$];
    logic [31:0] phys [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_last_dm = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C00_0000;
    endfunction

    function automatic logic [31:0] phys_read(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic dm_op_t mk_op(input logic r, input logic w, input logic [31:0] a,
                                     input logic [31:0] d);
        dm_op_t op;
        op.r = r; op.w = w; op.a = a; op.d = d;
        return op;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic issue_fetch(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(ref_read(a));
        $display("[%0t] fetch issue addr=0x%08h", $time, a);
    endtask

    task automatic issue_dm(input dm_op_t op);
        dm_cs = 1'b1; dm_r = op.r; dm_w = op.w; dm_addr = op.a; dm_wdata = op.d;
        if (op.w) begin
            ref_mem[op.a] = op.d;
        end else begin
            ref_last_dm = ref_read(op.a);
        end
        dm_q.push_back(ref_last_dm);
        $display("[%0t] data issue %s addr=0x%08h wdata=0x%08h", $time,
                 op.w ? "write" : "read", op.a, op.d);
    endtask

    task automatic idle_dm();
        dm_cs = 1'b0; dm_r = 1'b0; dm_w = 1'b0;
    endtask

    // Memory model: returns data only on the last BUSY cycle, noise otherwise.
    int mm_cnt = 0;
    always @(negedge clk) begin
        if (reset || !mem_en) mm_cnt = 0;
        else mm_cnt = mm_cnt + 1;
        if (!reset && mem_en && mm_cnt == W) begin
            if (mem_we) phys[mem_addr] = mem_wdata;
            mem_rdata = phys_read(mem_addr);
        end else begin
            mem_rdata = $urandom;
        end
    end

    // Monitor: pops expected responses on acks and checks bus-level timing properties.
    int          run_len = 0;
    int          d_while_i = 0;
    logic        prev_en = 1'b0;
    logic        prev_if_req = 1'b0;
    logic        run_with_if = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin : monitor
        logic [31:0] exp_v;
        if (reset) begin
            run_len = 0; prev_en = 1'b0; d_while_i = 0;
        end else begin
            if (if_ack) begin
                check(if_q.size() > 0, "if_ack_expected", 32'(if_q.size()), 32'd1);
                if (if_q.size() > 0) begin
                    exp_v = if_q.pop_front();
                    check(if_rdata === exp_v, "if_rdata", if_rdata, exp_v);
                    $display("[%0t] fetch ack rdata=0x%08h", $time, if_rdata);
                end
                d_while_i = 0;
            end
            if (dm_ack) begin
                check(dm_q.size() > 0, "dm_ack_expected", 32'(dm_q.size()), 32'd1);
                if (dm_q.size() > 0) begin
                    exp_v = dm_q.pop_front();
                    check(dm_rdata === exp_v, "dm_rdata", dm_rdata, exp_v);
                    $display("[%0t] data ack rdata=0x%08h", $time, dm_rdata);
                end
                if (run_with_if) begin
                    d_while_i++;
                    check(d_while_i <= 2, "fetch_starved", 32'(d_while_i), 32'd2);
                end else begin
                    d_while_i = 0;
                end
            end
            if (mem_en) begin
                if (prev_en) begin
                    check(mem_addr === prev_addr, "addr_stable", mem_addr, prev_addr);
                    run_len++;
                end else begin
                    run_len = 1;
                    run_with_if = prev_if_req;
                end
            end else if (prev_en) begin
                check(run_len == W, "busy_len", 32'(run_len), 32'(W));
                check((if_ack ^ dm_ack) === 1'b1, "ack_after_busy", {30'd0, if_ack, dm_ack}, 32'd1);
            end
            prev_en = mem_en; prev_addr = mem_addr; prev_if_req = if_req;
        end
    end

    // Trace capture for the directed scenarios; cycle 0 is the cycle the trace starts in.
    logic        tr_en[32], tr_we[32], tr_iack[32], tr_dack[32], tr_sf[32], tr_sm[32];
    logic [31:0] tr_addr[32], tr_wd[32], tr_drd[32];

    task automatic run_trace(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            tr_en[k] = mem_en; tr_we[k] = mem_we; tr_addr[k] = mem_addr; tr_wd[k] = mem_wdata;
            tr_iack[k] = if_ack; tr_dack[k] = dm_ack; tr_sf[k] = stall_f; tr_sm[k] = stall_m;
            tr_drd[k] = dm_rdata;
            @(posedge clk); #1;
            if (tr_iack[k]) if_req = 1'b0;
            if (tr_dack[k]) begin
                if (dq.size() > 0) issue_dm(dq.pop_front());
                else idle_dm();
            end
        end
    endtask

    task automatic fetch_driver(input int n);
        int gap, waited;
        bit got;
        for (int t = 0; t < n; t++) begin
            issue_fetch({24'd0, 6'($urandom_range(0, 63)), 2'b00});
            got = 1'b0; waited = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (if_ack) begin got = 1'b1; waited = c; break; end
            end
            check(got, "if_ack_timeout", {31'd0, got}, 32'd1);
            if (!got) break;
            check(waited < 4 * P, "if_wait_bound", 32'(waited), 32'(4 * P));
            @(posedge clk); #1;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                if_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic data_driver(input int n);
        int gap, waited, kind;
        bit got;
        for (int t = 0; t < n; t++) begin
            kind = $urandom_range(0, 3);
            issue_dm(mk_op(kind != 0, kind <= 1, 32'h100 + 32'($urandom_range(0, 15)) * 4,
                           $urandom));
            got = 1'b0; waited = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (dm_ack) begin got = 1'b1; waited = c; break; end
            end
            check(got, "dm_ack_timeout", {31'd0, got}, 32'd1);
            if (!got) break;
            check(waited < 2 * P, "dm_wait_bound", 32'(waited), 32'(2 * P));
            @(posedge clk); #1;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                idle_dm();
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        idle_dm();
    endtask

    initial begin
        phys[32'h40] = 32'h8C01_0004; ref_mem[32'h40] = 32'h8C01_0004;
        phys[32'h110] = 32'h11;       ref_mem[32'h110] = 32'h11;
        repeat (3) @(negedge clk);
        check(mem_en === 1'b0, "rst_mem_en", {31'd0, mem_en}, 32'd0);
        check(mem_we === 1'b0, "rst_mem_we", {31'd0, mem_we}, 32'd0);
        check(mem_addr === 32'd0, "rst_mem_addr", mem_addr, 32'd0);
        check(mem_wdata === 32'd0, "rst_mem_wdata", mem_wdata, 32'd0);
        check(if_ack === 1'b0 && dm_ack === 1'b0, "rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        check(if_rdata === 32'd0, "rst_if_rdata", if_rdata, 32'd0);
        check(dm_rdata === 32'd0, "rst_dm_rdata", dm_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single fetch
        issue_fetch(32'h40);
        run_trace(6);
        check(tr_sf[0] === 1'b1, "s1_stall_f_c0", {31'd0, tr_sf[0]}, 32'd1);
        check(tr_en[0] === 1'b0, "s1_en_c0", {31'd0, tr_en[0]}, 32'd0);
        check(tr_en[1] === 1'b1 && tr_addr[1] === 32'h40, "s1_mem_c1", tr_addr[1], 32'h40);
        check(tr_en[3] === 1'b1 && tr_sf[3] === 1'b1, "s1_busy_c3", {30'd0, tr_en[3], tr_sf[3]}, 32'd3);
        check(tr_iack[3] === 1'b0, "s1_no_ack_c3", {31'd0, tr_iack[3]}, 32'd0);
        check(tr_iack[4] === 1'b1, "s1_ack_c4", {31'd0, tr_iack[4]}, 32'd1);
        check(tr_en[4] === 1'b0 && tr_sf[4] === 1'b0, "s1_resp_c4", {30'd0, tr_en[4], tr_sf[4]}, 32'd0);
        check(tr_iack[5] === 1'b0, "s1_ack_pulse", {31'd0, tr_iack[5]}, 32'd0);

        // Simultaneous requests: data first, then fetch
        issue_fetch(32'h44);
        issue_dm(mk_op(1'b1, 1'b0, 32'h100, 32'd0));
        run_trace(11);
        check(tr_addr[1] === 32'h100, "s2_d_first", tr_addr[1], 32'h100);
        check(tr_sm[3] === 1'b1 && tr_sm[4] === 1'b0, "s2_stall_m", {30'd0, tr_sm[3], tr_sm[4]}, 32'd2);
        check(tr_dack[4] === 1'b1, "s2_dm_ack_c4", {31'd0, tr_dack[4]}, 32'd1);
        check(tr_en[6] === 1'b1 && tr_addr[6] === 32'h44, "s2_i_second", tr_addr[6], 32'h44);
        check(tr_iack[8] === 1'b0 && tr_iack[9] === 1'b1, "s2_if_ack_c9", {30'd0, tr_iack[8], tr_iack[9]}, 32'd1);

        // Starvation guard: D, D, I, D
        issue_fetch(32'h48);
        issue_dm(mk_op(1'b1, 1'b0, 32'h104, 32'd0));
        dq.push_back(mk_op(1'b1, 1'b0, 32'h108, 32'd0));
        dq.push_back(mk_op(1'b1, 1'b0, 32'h10C, 32'd0));
        run_trace(21);
        check(tr_dack[4] === 1'b1 && tr_dack[9] === 1'b1, "s3_two_d", {30'd0, tr_dack[4], tr_dack[9]}, 32'd3);
        check(tr_addr[11] === 32'h48, "s3_i_third", tr_addr[11], 32'h48);
        check(tr_iack[14] === 1'b1, "s3_if_ack_c14", {31'd0, tr_iack[14]}, 32'd1);
        check(tr_addr[16] === 32'h10C && tr_dack[19] === 1'b1, "s3_d_fourth", tr_addr[16], 32'h10C);

        // Stores leave dm_rdata alone; read+write is a write
        issue_dm(mk_op(1'b1, 1'b0, 32'h110, 32'd0));
        dq.push_back(mk_op(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF));
        dq.push_back(mk_op(1'b1, 1'b1, 32'h204, 32'hCAFE_F00D));
        dq.push_back(mk_op(1'b1, 1'b0, 32'h200, 32'd0));
        run_trace(21);
        check(tr_we[6] === 1'b1 && tr_addr[6] === 32'h200, "s4_we_addr", tr_addr[6], 32'h200);
        check(tr_wd[6] === 32'hDEAD_BEEF, "s4_wdata", tr_wd[6], 32'hDEAD_BEEF);
        check(tr_dack[9] === 1'b1 && tr_drd[9] === 32'h11, "s4_store_hold", tr_drd[9], 32'h11);
        check(tr_we[11] === 1'b1 && tr_wd[11] === 32'hCAFE_F00D, "s4_rw_is_write", tr_wd[11], 32'hCAFE_F00D);
        check(tr_drd[14] === 32'h11, "s4_rw_hold", tr_drd[14], 32'h11);
        check(tr_we[16] === 1'b0 && tr_drd[19] === 32'hDEAD_BEEF, "s4_readback", tr_drd[19], 32'hDEAD_BEEF);

        // Reset in the second BUSY cycle
        issue_fetch(32'h4C);
        @(negedge clk);
        @(negedge clk);
        check(mem_en === 1'b1, "s5_busy", {31'd0, mem_en}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check(mem_en === 1'b0, "s5_rst_mem_en", {31'd0, mem_en}, 32'd0);
        void'(if_q.pop_back());
        ref_last_dm = '0;
        repeat (3) begin
            @(negedge clk);
            check(if_ack === 1'b0 && dm_ack === 1'b0, "s5_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        end
        check(if_rdata === 32'd0, "s5_rst_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        if_q.push_back(ref_read(32'h4C));
        run_trace(6);
        check(tr_en[1] === 1'b1 && tr_addr[1] === 32'h4C, "s5_fresh_mem", tr_addr[1], 32'h4C);
        check(tr_iack[3] === 1'b0 && tr_iack[4] === 1'b1, "s5_fresh_ack", {30'd0, tr_iack[3], tr_iack[4]}, 32'd1);

        // Random traffic on both ports
        fork
            fetch_driver(40);
            data_driver(40);
        join
        repeat (2 * P) @(negedge clk);
        check(if_q.size() == 0, "if_q_drained", 32'(if_q.size()), 32'd0);
        check(dm_q.size() == 0, "dm_q_drained", 32'(dm_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported, fixed-latency unified memory between the pipeline's fetch stage (F) and memory stage (M). It grants one access at a time through an IDLE/BUSY/RESP state machine and returns read data with a one-cycle acknowledge pulse. It drives stall indications so the pipeline registers hold while an access is outstanding. It sits between the CPU core's fetch/`DM_*` outputs and the memory model.

## Interface
- `WAIT_CYCLES`, 1 — memory access latency in cycles; legal range 1..15.
- `AW`, 32 — address width.
- `DW`, 32 — data width.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `if_req` in 1 — fetch request, level, held until `if_ack`.
- `if_addr` in AW — fetch address.
- `if_rdata` out DW — fetched instruction; valid while `if_ack`=1.
- `if_ack` out 1 — one-cycle completion pulse.
- `dm_cs`, `dm_r`, `dm_w` in 1 each — data request qualifiers.
- `dm_addr` in AW — data address.
- `dm_wdata` in DW — store data.
- `dm_rdata` out DW — load data; valid while `dm_ack`=1.
- `dm_ack` out 1 — one-cycle completion pulse.
- `stall_f` out 1 — `if_req & ~if_ack`, combinational.
- `stall_m` out 1 — `dm_valid & ~dm_ack`, combinational.
- `mem_en` out 1 — memory enable.
- `mem_we` out 1 — memory write enable.
- `mem_addr` out AW — memory address.
- `mem_wdata` out DW — memory write data.
- `mem_rdata` in DW — memory read data; valid on the last BUSY cycle.

## Operation
- `dm_valid = dm_cs & (dm_r | dm_w)`. If `dm_r` and `dm_w` are both 1, the access is a write.
- **States:** IDLE, BUSY, RESP.
- **IDLE:** arbitrate at the clock edge:
  - If `dm_valid` and NOT (`d_streak`=2 and `if_req`): grant D.
  - Else if `if_req`: grant I.
  - Else stay in IDLE.
- **On grant:**
  - Latch owner, address, write flag and wdata into registers.
  - Load `cnt` = WAIT_CYCLES−1.
  - Go to BUSY.
- **d_streak** (2-bit): increments on a D grant while `if_req`=1, saturating at 2. It clears on any I grant, and on a D grant while `if_req`=0. This guarantees that a pending fetch waits at most 2 consecutive data accesses.
- **BUSY:**
  - `mem_en`=1, `mem_we`=latched write flag, `mem_addr`/`mem_wdata` = latched values, all stable for the whole state.
  - `cnt` decrements each cycle.
  - When `cnt`=0: capture `mem_rdata` into the owner's rdata register (reads only), then go to RESP.
- **RESP:**
  - Owner's ack=1 for exactly this cycle. `mem_en`=0.
  - Always go to IDLE. The requester deasserts or changes its request on the edge ending RESP.
- **Writes:** pulse `dm_ack` but leave `dm_rdata` unchanged.
- **Request dropped mid-BUSY:** the access completes anyway and the ack still pulses.
- **Request changes mid-BUSY:** ignored, because latched values are used.
- **Rdata hold:** `if_rdata` and `dm_rdata` hold their last captured value outside ack cycles.

## Timing
- **Reset (asynchronous):**
  - State returns to IDLE and `cnt`=0, `d_streak`=0.
  - `mem_en`, `mem_we`, `if_ack`, `dm_ack` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0.
  - An in-flight access is abandoned with no ack.
  - The first grant is possible at the first rising edge after `reset` falls.
- **Latency:** request sampled in IDLE at edge E0.
  - BUSY occupies cycles E0+1 .. E0+WAIT_CYCLES.
  - Ack is high in cycle E0+WAIT_CYCLES+1.
  - The next grant edge is at the end of the IDLE cycle E0+WAIT_CYCLES+2.
- **Throughput:** 1 access per WAIT_CYCLES+2 cycles under continuous load.
- **Control outputs:** `mem_*` outputs, acks and rdata are registered. The stalls are combinational from the inputs and ack.
- **Simultaneous events:**
  - A request arriving during BUSY/RESP waits for IDLE.
  - If both requests are present in IDLE, D wins, subject to `d_streak`.

## Test plan
- **Single fetch:** WAIT_CYCLES=1, `if_req`=1, `if_addr`=0x40 at cycle 0, memory returns 0x8C010004.
  - `mem_en`=1 with `mem_addr`=0x40 in cycle 1.
  - `if_ack`=1 with `if_rdata`=0x8C010004 in cycle 2.
  - `stall_f`=1 in cycles 0–1.
- **Simultaneous requests:** `if_req` (0x44) and a load (`dm_addr`=0x100) both in cycle 0.
  - D is served first: `mem_addr`=0x100 in cycle 1, `dm_ack` in cycle 2.
  - Then I: `mem_addr`=0x44 in cycle 4, `if_ack` in cycle 5.
- **Starvation guard:** `if_req` held high plus 3 back-to-back loads.
  - Grant order is D, D, I, D.
  - `if_ack` arrives before the 3rd `dm_ack`.
- **Store:** `dm_w`=1, `dm_addr`=0x200, `dm_wdata`=0xDEADBEEF, prior `dm_rdata`=0x11.
  - `mem_we`=1 with 0xDEADBEEF on `mem_wdata`.
  - `dm_ack` pulses; `dm_rdata` stays 0x11.
  - With `dm_r`=`dm_w`=1 the access is also a write.
- **Latency parameter:** WAIT_CYCLES=3, one load.
  - `mem_en` is high for exactly 3 cycles with `mem_addr` stable.
  - Ack appears in cycle 4; `mem_rdata` is sampled in cycle 3 only.
- **Reset mid-BUSY:** assert `reset` in the 2nd BUSY cycle (WAIT_CYCLES=3).
  - `mem_en`=0 immediately, no ack is ever produced.
  - After release with `if_req`=1, a fresh fetch completes with normal latency.
